// File: rtl/sd_block_responder.sv
// sd_block_responder: serves sector read/write requests from several
// block-device requesters over the sd_rd/sd_wr/sd_ack buffer interface.
// One sector (512 bytes) is moved per request between the requester's
// buffer and a byte-wide backing store with a mem_ready handshake.
module sd_block_responder #(
    parameter int UNITS     = 2,
    parameter int ACK_DELAY = 4,
    parameter int LBA_BITS  = 23
) (
    input  logic                                          clk_sys,
    input  logic                                          reset,
    input  logic [32*UNITS-1:0]                           sd_lba,
    input  logic [UNITS-1:0]                              sd_rd,
    input  logic [UNITS-1:0]                              sd_wr,
    output logic [UNITS-1:0]                              sd_ack,
    output logic [8:0]                                    sd_buff_addr,
    output logic [7:0]                                    sd_buff_dout,
    output logic                                          sd_buff_wr,
    input  logic [8*UNITS-1:0]                            sd_buff_din,
    output logic [LBA_BITS+8:0]                           mem_addr,
    output logic                                          mem_rd,
    output logic                                          mem_wr,
    output logic [7:0]                                    mem_wdata,
    input  logic [7:0]                                    mem_rdata,
    input  logic                                          mem_ready,
    output logic                                          busy,
    output logic [((UNITS > 1) ? $clog2(UNITS) : 1)-1:0]  active_unit
);

    localparam int UW = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam int CW = $clog2(ACK_DELAY) + 1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ACKW    = 4'd1,
        RD_REQ  = 4'd2,
        RD_PUT  = 4'd3,
        WR_ADDR = 4'd4,
        WR_WAIT = 4'd5,
        WR_CAP  = 4'd6,
        WR_REQ  = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t                 state_r;
    logic [UW-1:0]          unit_r;
    logic [LBA_BITS-1:0]    lba_r;
    logic                   is_wr_r;
    logic [8:0]             offset_r;
    logic [CW-1:0]          cnt_r;

    logic                   found_s;
    logic [UW-1:0]          pick_s;
    logic [LBA_BITS-1:0]    pick_lba_s;
    logic                   pick_rd_s;
    logic [7:0]             din_s;
    logic [UNITS-1:0]       ack_sel_s;
    logic                   lba_unused_s;

    // LBA bits above LBA_BITS do not take part in addressing
    assign lba_unused_s = ^sd_lba;

    // Priority pick: scan from the top so the lowest requesting index wins
    always_comb begin
        found_s    = 1'b0;
        pick_s     = '0;
        pick_lba_s = '0;
        pick_rd_s  = 1'b0;
        for (int u = UNITS - 1; u >= 0; u--) begin
            if (sd_rd[u] || sd_wr[u]) begin
                found_s    = 1'b1;
                pick_s     = UW'(u);
                pick_lba_s = sd_lba[u*32 +: LBA_BITS];
                pick_rd_s  = sd_rd[u];
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Steer the served unit's write-data lane and build its one-hot ack
    always_comb begin
        din_s     = 8'h00;
        ack_sel_s = '0;
        for (int u = 0; u < UNITS; u++) begin
            if (unit_r == UW'(u)) begin
                din_s        = sd_buff_din[u*8 +: 8];
                ack_sel_s[u] = 1'b1;
            end else begin
                ack_sel_s[u] = 1'b0;
            end
        end
    end

    // Transfer sequencer with all interface outputs registered
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            unit_r       <= '0;
            lba_r        <= '0;
            is_wr_r      <= 1'b0;
            offset_r     <= 9'd0;
            cnt_r        <= '0;
            sd_ack       <= '0;
            sd_buff_addr <= 9'd0;
            sd_buff_dout <= 8'h00;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= 8'h00;
            busy         <= 1'b0;
            active_unit  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        unit_r      <= pick_s;
                        lba_r       <= pick_lba_s;
                        is_wr_r     <= ~pick_rd_s;
                        offset_r    <= 9'd0;
                        cnt_r       <= CW'(ACK_DELAY - 1);
                        active_unit <= pick_s;
                        busy        <= 1'b1;
                        state_r     <= ACKW;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                ACKW: begin
                    if (cnt_r == '0) begin
                        sd_ack <= ack_sel_s;
                        if (is_wr_r) begin
                            sd_buff_addr <= 9'd0;
                            state_r      <= WR_ADDR;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= {lba_r, 9'd0};
                            state_r  <= RD_REQ;
                        end
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                RD_REQ: begin
                    // A stalled mem_ready simply holds here with ack high
                    if (mem_ready) begin
                        mem_rd       <= 1'b0;
                        sd_buff_dout <= mem_rdata;
                        sd_buff_addr <= offset_r;
                        sd_buff_wr   <= 1'b1;
                        state_r      <= RD_PUT;
                    end else begin
                        state_r      <= RD_REQ;
                    end
                end
                RD_PUT: begin
                    sd_buff_wr <= 1'b0;
                    if (offset_r == 9'd511) begin
                        sd_ack  <= '0;
                        state_r <= DONE;
                    end else begin
                        offset_r <= offset_r + 9'd1;
                        mem_rd   <= 1'b1;
                        mem_addr <= {lba_r, offset_r + 9'd1};
                        state_r  <= RD_REQ;
                    end
                end
                WR_ADDR: begin
                    state_r <= WR_WAIT;
                end
                WR_WAIT: begin
                    // Requester buffer RAM is registered: data lands one cycle after addr
                    state_r <= WR_CAP;
                end
                WR_CAP: begin
                    mem_wdata <= din_s;
                    mem_addr  <= {lba_r, offset_r};
                    mem_wr    <= 1'b1;
                    state_r   <= WR_REQ;
                end
                WR_REQ: begin
                    if (mem_ready) begin
                        mem_wr <= 1'b0;
                        if (offset_r == 9'd511) begin
                            sd_ack  <= '0;
                            state_r <= DONE;
                        end else begin
                            offset_r     <= offset_r + 9'd1;
                            sd_buff_addr <= offset_r + 9'd1;
                            state_r      <= WR_ADDR;
                        end
                    end else begin
                        state_r <= WR_REQ;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    sd_ack     <= '0;
                    sd_buff_wr <= 1'b0;
                    mem_rd     <= 1'b0;
                    mem_wr     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
Host-side block-device responder for the MiSTer-style sd_rd/sd_wr/sd_ack sector interface used by the HDD and floppy_track requesters in the simulation top. It accepts per-unit sector requests (sd_lba, sd_rd, sd_wr) and arbitrates between units. For reads it streams 512 bytes into the requester's buffer via sd_buff_addr/sd_buff_dout/sd_buff_wr. For writes it pulls 512 bytes from sd_buff_din. Sector data moves to or from a byte-wide backing-store port, either an image RAM or a C++ bridge.

Parameters:
UNITS, 2, number of block-device units served (index 0 = highest priority)
ACK_DELAY, 4, clk_sys cycles from request latch to sd_ack rise (min 1)
LBA_BITS, 23, LBA bits used when forming the backing-store address

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
sd_lba  in  32*UNITS  per-unit LBA; unit u at [32u+31:32u]
sd_rd  in  UNITS  per-unit read request (level)
sd_wr  in  UNITS  per-unit write request (level)
sd_ack  out  UNITS  per-unit acknowledge; high for the whole transfer
sd_buff_addr  out  9  byte offset within sector
sd_buff_dout  out  8  read data to requester
sd_buff_wr  out  1  one-cycle strobe qualifying sd_buff_addr/sd_buff_dout
sd_buff_din  in  8*UNITS  per-unit write data from requester buffer; unit u at [8u+7:8u]
mem_addr  out  LBA_BITS+9  backing-store byte address = {lba[LBA_BITS-1:0], offset}
mem_rd  out  1  backing-store read request (level until mem_ready)
mem_wr  out  1  backing-store write request (level until mem_ready)
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid when mem_ready is high
mem_ready  in  1  completes the current mem_rd/mem_wr in that cycle
busy  out  1  high in any state other than IDLE
active_unit  out  $clog2(UNITS) max 1  unit being served

Behaviour:
- Reset (async): state=IDLE. sd_ack=0, sd_buff_wr=0, sd_buff_addr=0, sd_buff_dout=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, active_unit=0. A transfer in progress is abandoned and ack drops immediately.
- States: IDLE, ACKW, RD_REQ, RD_PUT, WR_ADDR, WR_WAIT, WR_CAP, WR_REQ, DONE.
- IDLE: if any sd_rd|sd_wr bit is set, pick the lowest-index requesting unit and latch unit, lba and direction. If both rd and wr are set on that unit, rd wins. Offset is set to 0, delay counter to ACK_DELAY-1, and the state moves to ACKW. Requests are sampled only in IDLE; later changes are ignored until DONE.
- ACKW: count down. At 0, set sd_ack[unit]=1. Next state is RD_REQ for a read or WR_ADDR for a write.
- Read path:
  - RD_REQ: mem_rd=1, mem_addr={lba,offset}. On mem_ready, latch mem_rdata, drop mem_rd, go to RD_PUT.
  - RD_PUT: one cycle with sd_buff_wr=1, sd_buff_addr=offset, sd_buff_dout=latched byte. If offset==511 go to DONE; otherwise offset+1 and back to RD_REQ.
  - At most one sd_buff_wr strobe per two cycles.
- Write path:
  - WR_ADDR: drive sd_buff_addr=offset.
  - WR_WAIT: one cycle, covering the requester's registered-RAM latency.
  - WR_CAP: sample sd_buff_din[unit] into mem_wdata.
  - WR_REQ: mem_wr=1 until mem_ready. Then, if offset==511, go to DONE; otherwise offset+1 and back to WR_ADDR.
  - sd_buff_addr holds its value from WR_ADDR through WR_REQ.
- DONE: sd_ack[unit]=0 for one cycle, then IDLE. Ack low time between transfers is at least 2 cycles.
- If the requester still holds rd/wr when IDLE is re-entered, the request is serviced again. Requesters drop rd/wr on the ack rising edge.
- Offset is 9 bits; the wrap at 511 ends the sector, with no wrap into the next LBA.
- LBA bits above LBA_BITS are ignored.
- mem_ready may already be high when a request is raised; completion then happens in 1 cycle. No timeout: an indefinite mem_ready stall holds the state and ack.
- sd_ack is one-hot or zero, never multiple bits.

Test Plan:
- Read unit0 lba=5, mem[i]=i[7:0]. sd_rd[0] rises:
  - sd_ack[0] rises 1+ACK_DELAY cycles later.
  - 512 sd_buff_wr strobes at addr 0..511 with dout = (2560+i)&FF.
  - mem_addr runs 0xA00..0xBFF; ack falls after strobe 511.
- Write unit1 lba=2, requester RAM returns din=~addr with 1-cycle latency: mem written at 0x400+i with ~i[7:0] for i=0..511, sd_ack[1] only, sd_ack[0]=0 throughout.
- sd_rd[0] and sd_rd[1] rise in the same cycle: unit0 serviced first. Unit1 ack rises at least 2 cycles after unit0 ack falls, and active_unit changes 0->1.
- mem_ready held low 10 cycles on byte 100 of a read: no sd_buff_wr during the stall, then byte 100 correct and the sequence continues; total strobes = 512.
- reset pulsed (asynchronously, mid-cycle) at byte 300 of a write: all outputs 0 immediately. A new sd_rd[0] afterwards completes a full 512-byte read normally.
- sd_rd[0] and sd_wr[0] both high: read performed first. With sd_wr still held after DONE, a write follows.
